// File: rtl/xe1ap_multimode_if.sv
// Pad-side bundle between the PC Engine port multiplexer (master) and the
// XE-1AP emulator (slave): request in, handshake lines and status out.
interface xe1ap_multimode_if;
    logic       req;
    logic       trg1;
    logic       trg2;
    logic [3:0] data;
    logic       run_btn;
    logic       select_btn;
    logic       busy;
    logic       done;

    modport master (
        output req,
        input  trg1, trg2, data, run_btn, select_btn, busy, done
    );

    modport slave (
        input  req,
        output trg1, trg2, data, run_btn, select_btn, busy, done
    );
endinterface

// File: rtl/xe1ap_multimode.sv
// XE-1AP analog pad emulator: on a synchronised req edge, snapshot the pad and
// stream a 12-nibble frame over data/trg1/trg2 with microsecond-accurate timing.
//
// state | meaning
// IDLE  | waiting for a req edge, outputs parked
// LEAD  | lead-in delay before the first nibble
// CYC   | one of six two-nibble handshake cycles
// FIN   | single-clock wrap-up, pulses done
module xe1ap_multimode #(
    parameter int CLKPERUSEC = 50,
    parameter int T_FIRST    = 68,
    parameter int T_ACK      = 13,
    parameter int T_LO       = 17,
    parameter int T_HI       = 30,
    parameter int T_TRG1     = 34,
    parameter int T_PERIOD   = 50,
    parameter int SLOW_MULT  = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [31:0]      joystick_0,
    input  logic [15:0]      joystick_l_analog_0,
    input  logic [15:0]      joystick_r_analog_0,
    input  logic             slow_mode,
    xe1ap_multimode_if.slave pad
);
    localparam int T_LONG = (T_FIRST > T_PERIOD) ? T_FIRST : T_PERIOD;
    localparam int US_W0  = $clog2(T_LONG * SLOW_MULT + 1);
    localparam int US_W   = (US_W0 > 9) ? US_W0 : 9;
    localparam logic [7:0] TICK_LOAD = 8'(CLKPERUSEC - 1);

    typedef enum logic [1:0] {IDLE, LEAD, CYC, FIN} state_t;

    state_t          state_q, state_d;
    logic            req_s1_q, req_s1_d, req_s2_q, req_s2_d, req_s3_q, req_s3_d;
    logic [7:0]      tick_q, tick_d;
    logic [US_W-1:0] us_q, us_d;
    logic [2:0]      cyc_q, cyc_d;
    logic            slow_q, slow_d;
    logic [47:0]     frame_q, frame_d;
    logic            trg1_q, trg1_d, trg2_q, trg2_d;
    logic [3:0]      data_q, data_d;
    logic            run_q, run_d, sel_q, sel_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic            req_edge;
    logic            tick;
    logic [US_W-1:0] us_inc;
    logic [US_W-1:0] t_first, t_ack, t_lo, t_hi, t_trg1, t_period;
    logic [7:0]      off_x, off_y, thr;
    logic [3:0]      nib_btn, nib_sys;
    logic [47:0]     snapshot;
    logic            unused_inputs;

    function automatic logic [US_W-1:0] eff(input int t, input logic slow);
        return slow ? US_W'(t * SLOW_MULT) : US_W'(t);
    endfunction

    assign req_edge = req_s2_q & ~req_s3_q;
    assign us_inc   = us_q + US_W'(1);

    assign t_first  = eff(T_FIRST,  slow_q);
    assign t_ack    = eff(T_ACK,    slow_q);
    assign t_lo     = eff(T_LO,     slow_q);
    assign t_hi     = eff(T_HI,     slow_q);
    assign t_trg1   = eff(T_TRG1,   slow_q);
    assign t_period = eff(T_PERIOD, slow_q);

    // Signed axes become offset binary; throttle is inverted offset binary.
    assign off_y   = {~joystick_l_analog_0[15], joystick_l_analog_0[14:8]};
    assign off_x   = {~joystick_l_analog_0[7],  joystick_l_analog_0[6:0]};
    assign thr     = ~{~joystick_r_analog_0[15], joystick_r_analog_0[14:8]};
    assign nib_btn = {~joystick_0[4], ~joystick_0[5], 2'b11};
    assign nib_sys = {2'b11, ~joystick_0[7], ~joystick_0[6]};

    // Nibble 1 sits in the low bits; the frame shifts right as nibbles go out.
    assign snapshot = {4'hF, nib_btn, 4'h0, thr[3:0], off_x[3:0], off_y[3:0],
                       4'h0, thr[7:4], off_x[7:4], off_y[7:4], nib_sys, nib_btn};

    assign unused_inputs = ^{joystick_0[31:8], joystick_0[3:0], joystick_r_analog_0[7:0]};

    always_comb begin
        state_d  = state_q;
        req_s1_d = pad.req;
        req_s2_d = req_s1_q;
        req_s3_d = req_s2_q;
        tick_d   = tick_q;
        us_d     = us_q;
        cyc_d    = cyc_q;
        slow_d   = slow_q;
        frame_d  = frame_q;
        trg1_d   = trg1_q;
        trg2_d   = trg2_q;
        data_d   = data_q;
        run_d    = run_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tick     = 1'b0;

        if (state_q != IDLE) begin
            if (tick_q == 8'd0) begin
                tick   = 1'b1;
                tick_d = TICK_LOAD;
                us_d   = us_inc;
            end else begin
                tick_d = tick_q - 8'd1;
            end
        end

        // A req edge in any state (re)starts the transfer without a done pulse.
        if (req_edge) begin
            state_d = LEAD;
            frame_d = snapshot;
            slow_d  = slow_mode;
            run_d   = ~joystick_0[7];
            sel_d   = ~joystick_0[6];
            busy_d  = 1'b1;
            us_d    = '0;
            tick_d  = TICK_LOAD;
            cyc_d   = 3'd0;
            trg1_d  = 1'b0;
            trg2_d  = 1'b1;
            data_d  = 4'hF;
        end else begin
            case (state_q)
                IDLE: ;
                LEAD: begin
                    if (tick && us_inc == t_first) begin
                        data_d  = frame_q[3:0];
                        frame_d = {4'hF, frame_q[47:4]};
                        trg2_d  = 1'b0;
                        cyc_d   = 3'd1;
                        us_d    = '0;
                        state_d = CYC;
                    end
                end
                CYC: begin
                    if (tick) begin
                        if (us_inc == t_ack) begin
                            trg1_d = 1'b1;
                            trg2_d = 1'b1;
                        end
                        if (us_inc == t_lo) begin
                            data_d  = frame_q[3:0];
                            frame_d = {4'hF, frame_q[47:4]};
                            trg2_d  = 1'b0;
                        end
                        if (us_inc == t_hi) begin
                            trg2_d = 1'b1;
                        end
                        if (us_inc == t_trg1) begin
                            trg1_d = 1'b0;
                            if (cyc_q == 3'd6) begin
                                state_d = FIN;
                            end
                        end
                        if (us_inc == t_period) begin
                            data_d  = frame_q[3:0];
                            frame_d = {4'hF, frame_q[47:4]};
                            trg2_d  = 1'b0;
                            cyc_d   = cyc_q + 3'd1;
                            us_d    = '0;
                        end
                    end
                end
                FIN: begin
                    trg1_d  = 1'b0;
                    trg2_d  = 1'b1;
                    data_d  = 4'hF;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
            req_s3_q <= 1'b0;
            tick_q   <= 8'd0;
            us_q     <= '0;
            cyc_q    <= 3'd0;
            slow_q   <= 1'b0;
            frame_q  <= '1;
            trg1_q   <= 1'b0;
            trg2_q   <= 1'b1;
            data_q   <= 4'hF;
            run_q    <= 1'b1;
            sel_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_s1_q <= req_s1_d;
            req_s2_q <= req_s2_d;
            req_s3_q <= req_s3_d;
            tick_q   <= tick_d;
            us_q     <= us_d;
            cyc_q    <= cyc_d;
            slow_q   <= slow_d;
            frame_q  <= frame_d;
            trg1_q   <= trg1_d;
            trg2_q   <= trg2_d;
            data_q   <= data_d;
            run_q    <= run_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign pad.trg1       = trg1_q;
    assign pad.trg2       = trg2_q;
    assign pad.data       = data_q;
    assign pad.run_btn    = run_q;
    assign pad.select_btn = sel_q;
    assign pad.busy       = busy_q;
    assign pad.done       = done_q;
endmodule
